// File: rtl/gray_decoder.sv
// gray_decoder: streaming Gray-to-binary decoder with a valid/ready handshake
// and one registered output stage.
// Optional step checker enabled by defining GRAYDEC_STEP_CHECK_EN: flags
// repeated codes and multi-bit steps between consecutive accepted words, and
// keeps a saturating, clearable count of the multi-bit steps.
module gray_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             repeat_flag,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);

  logic accept;

  // Prefix XOR from the MSB down: bin[i] = bin[i+1] ^ g[i].
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      b[WIDTH-1-k] = b[WIDTH-k] ^ g[WIDTH-1-k];
    end
    return b;
  endfunction

  // The output register can take a word when empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output stage: load on accept, otherwise drop valid once delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bin_out   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bin_out   <= gray2bin(gray_in);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAYDEC_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             has_prev;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             step_hit;

  assign diff      = gray_in ^ prev_gray;
  // x & (x-1) clears the lowest set bit; anything left means >1 bit differs.
  assign multi_bit = |(diff & (diff - WIDTH'(1)));
  assign step_hit  = has_prev && multi_bit;

  // Remember the last accepted code and flag repeats / multi-bit steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray   <= '0;
      has_prev    <= 1'b0;
      repeat_flag <= 1'b0;
      step_err    <= 1'b0;
    end else if (accept) begin
      prev_gray   <= gray_in;
      has_prev    <= 1'b1;
      repeat_flag <= has_prev && (diff == '0);
      step_err    <= step_hit;
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= (accept && step_hit) ? CNT_W'(1) : '0;
    end else if (accept && step_hit && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  logic unused_clr_err;

  assign repeat_flag    = 1'b0;
  assign step_err       = 1'b0;
  assign err_count      = '0;
  assign unused_clr_err = clr_err;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder (WIDTH=4, CNT_W=2).
module tb_gray_decoder;

`ifdef GRAYDEC_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] gray_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] bin_out;
  logic       repeat_flag;
  logic       step_err;
  logic [1:0] err_count;
  logic       clr_err;

  gray_decoder #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .repeat_flag(repeat_flag), .step_err(step_err),
    .err_count(err_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bin;
    logic       rep;
    logic       serr;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       m_ovalid;
  logic       m_has_prev;
  logic [3:0] m_prev;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    return b;
  endfunction

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    sb.delete();
    m_ovalid   = 1'b0;
    m_has_prev = 1'b0;
    m_prev     = '0;
    m_cnt      = 0;
  endtask

  // One clock cycle: drive at negedge, check at +1, update model for the edge.
  task automatic cycle(input logic v, input logic [3:0] g, input logic ordy, input logic clr);
    exp_t e;
    logic acc;
    @(negedge clk);
    in_valid  = v;
    gray_in   = g;
    out_ready = ordy;
    clr_err   = clr;
    #1;
    check("in_ready", in_ready, !m_ovalid || ordy);
    check("out_valid", out_valid, m_ovalid);
    check("err_count", err_count, m_cnt);
    if (m_ovalid && sb.size() > 0) begin
      check("bin_out", bin_out, sb[0].bin);
      check("repeat_flag", repeat_flag, sb[0].rep);
      check("step_err", step_err, sb[0].serr);
    end
    acc = v && (!m_ovalid || ordy);
    if (m_ovalid && ordy && sb.size() > 0) void'(sb.pop_front());
    e.bin  = g2b(g);
    e.rep  = CHK && m_has_prev && (g == m_prev);
    e.serr = CHK && m_has_prev && ($countones(g ^ m_prev) > 1);
    if (CHK) begin
      if (clr) m_cnt = (acc && e.serr) ? 1 : 0;
      else if (acc && e.serr && m_cnt < 3) m_cnt++;
    end
    if (acc) begin
      sb.push_back(e);
      m_ovalid   = 1'b1;
      m_has_prev = 1'b1;
      m_prev     = g;
    end else if (ordy) begin
      m_ovalid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; gray_in = '0; out_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_bin_out", bin_out, 0);
    check("rst_repeat", repeat_flag, 0);
    check("rst_step_err", step_err, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate stream of bin 0..15
    for (int i = 0; i < 16; i++) cycle(1'b1, b2g(i), 1'b1, 1'b0);
    // Wrap and repeat: 1000 -> 0000 -> 0000
    cycle(1'b1, 4'b0000, 1'b1, 1'b0);
    cycle(1'b1, 4'b0000, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);

    // Step error, then clear together with another erroring accept
    cycle(1'b1, 4'b0001, 1'b1, 1'b0);
    cycle(1'b1, 4'b0111, 1'b1, 1'b0);
    cycle(1'b1, 4'b0001, 1'b1, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);

    // Backpressure: bin 3 pending while 0110 waits
    cycle(1'b1, 4'b0010, 1'b1, 1'b0);
    cycle(1'b1, 4'b0110, 1'b0, 1'b0);
    cycle(1'b1, 4'b0110, 1'b0, 1'b0);
    cycle(1'b1, 4'b0110, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 1'b1);

    // Saturation: consecutive 2-bit steps
    for (int i = 0; i < 6; i++) cycle(1'b1, (i % 2 == 0) ? 4'b0011 : 4'b0000, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);

    // Random traffic with backpressure and occasional clears
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0));
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);

    // Asynchronous reset between edges while a result is pending
    cycle(1'b1, 4'b0101, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_bin_out", bin_out, 0);
    check("arst_step_err", step_err, 0);
    check("arst_err_count", err_count, 0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    cycle(1'b1, 4'b1111, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);
    check("first_after_rst", g2b(4'b1111), 4'b1010);
    cycle(1'b0, 4'b0000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
